multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore/Mealy control FSM that sequences the shared single-ALU, single-memory datapath (instruction decoder, ALU decoder, register file, ALU) over multiple cycles per instruction.
- Issues fetch/decode/execute/memory/writeback strobes.
- Waits on a memory ready handshake.
- Halts on illegal opcodes.
- Sits beside the CPU datapath; consumes the opcode field and ALU zero flag.

Parameters:
- OP_W, 6, opcode field width (inst[31:26]).
- HALT_ON_ILLEGAL, 1, 1 = enter HALT on unknown opcode; 0 = treat as NOP and return to FETCH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- opcode  input  6  inst[31:26] from instruction register.
- alu_zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current read/write this cycle.
- pc_en  output  1  PC register load enable.
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALU result register.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  instruction register load.
- reg_write  output  1  register file write enable.
- reg_dst  output  1  write address: 0 = rt, 1 = rd.
- mem_to_reg  output  1  write data: 0 = ALU out, 1 = memory data.
- alu_src_a  output  1  0 = PC, 1 = rs data.
- alu_src_b  output  2  00 = rt data, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- alu_op  output  2  to ALU decoder: 00 = add, 01 = sub, 10 = use funct.
- pc_source  output  2  00 = ALU result, 01 = ALU out register, 10 = jump target.
- halted  output  1  sticky; high while in HALT.
- state_o  output  4  current state encoding, for debug.

Behaviour:
- State encoding: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, RTEXE = 6, ALUWB = 7, BRANCH = 8, ADDIEXE = 9, ADDIWB = 10, JUMP = 11, HALT = 12.
- Reset: on a clk edge with rst = 1, state becomes FETCH and halted = 0.
- While rst = 1, all strobes (pc_en, mem_read, mem_write, ir_write, reg_write) are forced to 0 combinationally. All selects default to 0.
- Default outputs: any output not listed for a state is 0 in that state.
- FETCH:
  - Drives mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write and pc_en are asserted only in a cycle where mem_ready = 1; that same cycle, move to DECODE.
  - If mem_ready = 0, stay in FETCH with mem_read held high.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target precompute). Next state by opcode:
  - 6'h00 → RTEXE
  - 6'h23 (lw) and 6'h2B (sw) → MEMADR
  - 6'h04 (beq) → BRANCH
  - 6'h08 (addi) → ADDIEXE
  - 6'h02 (j) → JUMP
  - any other opcode → HALT when HALT_ON_ILLEGAL = 1, else FETCH
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next state: MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read = 1, i_or_d = 1. Wait for mem_ready, then go to MEMWB.
- MEMWB: reg_write = 1, reg_dst = 0, mem_to_reg = 1. Next state FETCH.
- MEMWR: mem_write = 1, i_or_d = 1. Wait for mem_ready, then go to FETCH.
- RTEXE: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Next state ALUWB.
- ALUWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Next state FETCH.
- ADDIEXE: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next state ADDIWB.
- ADDIWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Next state FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_source = 01, pc_en = alu_zero. Next state FETCH.
- JUMP: pc_source = 10, pc_en = 1. Next state FETCH.
- HALT:
  - All strobes 0; halted = 1; stays in HALT until rst.
  - mem_ready is ignored in HALT.
- Cycle counts with mem_ready always high (FETCH through the last state):
  - R-type 4, addi 4, lw 5, sw 4, beq 3, j 3.
  - Each wait cycle with mem_ready = 0 adds one cycle.
- mem_ready is sampled only in FETCH, MEMRD and MEMWR; it is a don't-care in all other states.
- Reset mid-operation: rst = 1 in any state, including during an outstanding MEMRD/MEMWR, aborts the operation.
  - mem_read/mem_write drop in the same cycle.
  - No reg_write or pc_en occurs.
  - FETCH is entered on the next edge.
- Illegal state codes 13–15 go to FETCH on the next edge.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- When defined, adds two outputs, both cleared by rst and saturating at 32'hFFFFFFFF:
  - cycle_cnt  output  32: increments every non-reset, non-HALT cycle.
  - retired_cnt  output  32: increments on each transition into FETCH from MEMWB, MEMWR (with mem_ready = 1), ALUWB, ADDIWB, BRANCH or JUMP.
- When undefined, neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset: hold rst = 1 for 2 cycles → state_o = 0, every strobe 0, halted = 0; release → mem_read = 1 in FETCH.
- R-type, opcode 6'h00, mem_ready tied 1 → states 0, 1, 6, 7, 0; reg_write = 1 with reg_dst = 1 only in state 7; alu_op = 10 in state 6; 4 cycles total.
- lw, opcode 6'h23, with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMRD → ir_write is a single pulse on the ready cycle; MEMRD lasts 4 cycles; MEMWB asserts reg_write = 1 and mem_to_reg = 1; 10 cycles total.
- beq, opcode 6'h04: alu_zero = 1 → pc_en = 1 with pc_source = 01 in BRANCH; repeat with alu_zero = 0 → pc_en = 0; both return to FETCH after 3 cycles.
- Illegal opcode 6'h3F with HALT_ON_ILLEGAL = 1 → HALT after DECODE; halted = 1; no strobes for 20 cycles despite mem_ready toggling; rst → FETCH.
- sw, opcode 6'h2B, with rst asserted during the second MEMWR wait cycle → mem_write = 0 in that same cycle; next state_o = 0; no extra pc_en; with MULTICYCLE_CTRL_PERF_EN defined, retired_cnt = 0 after the reset.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multi-cycle single-ALU, single-memory CPU.
// It sequences fetch, decode, execute, memory and writeback steps.
// It stalls on the mem_ready handshake in FETCH, MEMRD and MEMWR.
// An unknown opcode either halts the FSM or is treated as a NOP (HALT_ON_ILLEGAL).
// Optional feature: define MULTICYCLE_CTRL_PERF_EN to add the saturating
// cycle_cnt and retired_cnt performance counters.
module multicycle_ctrl #(
  parameter int OP_W            = 6,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode,
  input  logic            alu_zero,
  input  logic            mem_ready,
  output logic            pc_en,
  output logic            i_or_d,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_source,
  output logic            halted,
  output logic [3:0]      state_o
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0]     cycle_cnt,
  output logic [31:0]     retired_cnt
`endif
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTEXE   = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEXE = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    HALT    = 4'd12
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'h08);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);

  localparam state_t ILLEGAL_NEXT = (HALT_ON_ILLEGAL != 0) ? HALT : FETCH;

  state_t state;

  // State register: sequencing per opcode, memory stalls, and recovery
  // from the unused codes 13-15.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:   if (mem_ready) state <= DECODE;
        DECODE: begin
          if (opcode == OP_RTYPE)                        state <= RTEXE;
          else if (opcode == OP_LW || opcode == OP_SW)   state <= MEMADR;
          else if (opcode == OP_BEQ)                     state <= BRANCH;
          else if (opcode == OP_ADDI)                    state <= ADDIEXE;
          else if (opcode == OP_J)                       state <= JUMP;
          else                                           state <= ILLEGAL_NEXT;
        end
        MEMADR:  state <= (opcode == OP_SW) ? MEMWR : MEMRD;
        MEMRD:   if (mem_ready) state <= MEMWB;
        MEMWB:   state <= FETCH;
        MEMWR:   if (mem_ready) state <= FETCH;
        RTEXE:   state <= ALUWB;
        ALUWB:   state <= FETCH;
        ADDIEXE: state <= ADDIWB;
        ADDIWB:  state <= FETCH;
        BRANCH:  state <= FETCH;
        JUMP:    state <= FETCH;
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // Output decode. ir_write, pc_en in FETCH and pc_en in BRANCH follow the
  // inputs in the same cycle. Reset silences every strobe and select at once,
  // which aborts an outstanding memory access.
  always_comb begin
    pc_en      = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    if (!rst) begin
      case (state)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
        end
        DECODE:  alu_src_b = 2'b11;
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEMWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        RTEXE: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        ADDIEXE: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        ADDIWB:  reg_write = 1'b1;
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_source = 2'b01;
          pc_en     = alu_zero;
        end
        JUMP: begin
          pc_source = 2'b10;
          pc_en     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign halted  = (state == HALT);
  assign state_o = state;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic count_cycle;
  logic retire;

  assign count_cycle = !rst && (state != HALT);
  // An instruction retires on its final edge back into FETCH.
  assign retire = !rst && ((state == MEMWB) || (state == ALUWB) ||
                           (state == ADDIWB) || (state == BRANCH) ||
                           (state == JUMP) || (state == MEMWR && mem_ready));

  // Saturating performance counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      if (count_cycle && cycle_cnt != 32'hFFFF_FFFF)  cycle_cnt   <= cycle_cnt + 32'd1;
      if (retire && retired_cnt != 32'hFFFF_FFFF)     retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl. The driver walks each instruction
// through its state sequence from a per-opcode table and inserts random memory
// stalls. It pushes the expected outputs for every cycle into a queue. A
// monitor pops one entry at each falling edge and compares it with the DUT.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       alu_zero;
  logic       mem_ready;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, halted;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_o;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt, retired_cnt;
`endif

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .halted(halted), .state_o(state_o)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic        pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic        reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic        halted;
    logic [31:0] cyc, ret;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_cyc = 0;
  int   m_ret = 0;

  // Expected outputs for one cycle spent in state s.
  function automatic exp_t expect_out(input int s, input logic r, input logic rdy, input logic z);
    exp_t e;
    e        = '0;
    e.st     = 4'(s);
    e.halted = (s == 12);
    if (!r) begin
      case (s)
        0:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_en = rdy; end
        1:  e.alu_src_b = 2'b11;
        2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
        3:  begin e.mem_read = 1; e.i_or_d = 1; end
        4:  begin e.reg_write = 1; e.mem_to_reg = 1; end
        5:  begin e.mem_write = 1; e.i_or_d = 1; end
        6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
        7:  begin e.reg_write = 1; e.reg_dst = 1; end
        8:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_source = 2'b01; e.pc_en = z; end
        9:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
        10: e.reg_write = 1;
        11: begin e.pc_source = 2'b10; e.pc_en = 1; end
        default: ;
      endcase
    end
`ifdef MULTICYCLE_CTRL_PERF_EN
    e.cyc = 32'(m_cyc);
    e.ret = 32'(m_ret);
`endif
    return e;
  endfunction

  // Drive one cycle in state s, record what is expected, then cross the edge.
  task automatic step(input int s, input logic r, input logic rdy);
    logic z;
    z         = 1'($urandom);
    rst       = r;
    mem_ready = rdy;
    alu_zero  = z;
    q.push_back(expect_out(s, r, rdy, z));
    @(posedge clk);
    #1;
    if (r) begin
      m_cyc = 0;
      m_ret = 0;
    end else if (s != 12) begin
      m_cyc++;
    end
  endtask

  // Memory-facing state: some number of stalls, then the ready cycle.
  task automatic mem_step(input int s, input int stalls);
    repeat (stalls) step(s, 1'b0, 1'b0);
    step(s, 1'b0, 1'b1);
  endtask

  // Run a whole instruction. A negative stall count means a random one.
  // An illegal opcode halts, idles 20 cycles with mem_ready toggling, then resets.
  task automatic run_op(input logic [5:0] op, input int fstall, input int mstall);
    int fs, ms;
    fs     = (fstall < 0) ? int'($urandom_range(0, 3)) : fstall;
    ms     = (mstall < 0) ? int'($urandom_range(0, 3)) : mstall;
    opcode = op;
    mem_step(0, fs);
    step(1, 1'b0, 1'($urandom));
    case (op)
      6'h00: begin step(6, 0, 1'($urandom)); step(7, 0, 1'($urandom)); end
      6'h23: begin step(2, 0, 1'($urandom)); mem_step(3, ms); step(4, 0, 1'($urandom)); end
      6'h2B: begin step(2, 0, 1'($urandom)); mem_step(5, ms); end
      6'h04: step(8, 0, 1'($urandom));
      6'h08: begin step(9, 0, 1'($urandom)); step(10, 0, 1'($urandom)); end
      6'h02: step(11, 0, 1'($urandom));
      default: begin
        for (int i = 0; i < 20; i++) step(12, 1'b0, 1'(i));
        step(12, 1'b1, 1'($urandom));
        return;
      end
    endcase
    m_ret++;
  endtask

  // Monitor: compare one scoreboard entry against the DUT per cycle.
  always @(negedge clk) begin
    exp_t e, a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '0;
      a.st = state_o; a.pc_en = pc_en; a.i_or_d = i_or_d; a.mem_read = mem_read;
      a.mem_write = mem_write; a.ir_write = ir_write; a.reg_write = reg_write;
      a.reg_dst = reg_dst; a.mem_to_reg = mem_to_reg; a.alu_src_a = alu_src_a;
      a.alu_src_b = alu_src_b; a.alu_op = alu_op; a.pc_source = pc_source;
      a.halted = halted;
`ifdef MULTICYCLE_CTRL_PERF_EN
      a.cyc = cycle_cnt; a.ret = retired_cnt;
`endif
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t actual=%h required=%h (state act %0d req %0d)",
                 $time, a, e, a.st, e.st);
      end
    end
  end

  // Stimulus.
  initial begin
    logic [5:0] legal [6];
    legal = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
    rst = 1'b1; opcode = '0; alu_zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    step(0, 1'b1, 1'b1);
    step(0, 1'b1, 1'b0);
    // Directed: R-type no stalls, lw with 2/3 stalls, beq taken/not, sw, addi, j.
    run_op(6'h00, 0, 0);
    run_op(6'h23, 2, 3);
    opcode = 6'h04;
    mem_step(0, 0); step(1, 0, 1);
    rst = 0; mem_ready = 1; alu_zero = 1'b1;
    q.push_back(expect_out(8, 1'b0, 1'b1, 1'b1));
    @(posedge clk); #1; m_cyc++; m_ret++;
    mem_step(0, 0); step(1, 0, 1);
    alu_zero = 1'b0;
    q.push_back(expect_out(8, 1'b0, 1'b1, 1'b0));
    @(posedge clk); #1; m_cyc++; m_ret++;
    run_op(6'h2B, 0, 0);
    run_op(6'h08, 0, 0);
    run_op(6'h02, 0, 0);
    // Random legal instruction stream.
    for (int i = 0; i < 300; i++) run_op(legal[$urandom_range(0, 5)], -1, -1);
    // Illegal opcode halts until reset.
    run_op(6'h3F, 0, 0);
    run_op(6'h00, 1, 0);
    run_op(6'h11, -1, -1);
    // sw aborted by reset during the second MEMWR wait cycle.
    opcode = 6'h2B;
    mem_step(0, 0); step(1, 0, 1); step(2, 0, 1);
    step(5, 1'b0, 1'b0);
    step(5, 1'b1, 1'b0);
    run_op(6'h2B, 0, 1);
    run_op(6'h23, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
